// File: rtl/branch_update_scheduler.sv
// Buffers up to two committed branches per cycle and feeds them one per cycle to the
// tournament predictor, with history restore on mispredict and a post-reset table-init walk.
module branch_update_scheduler #(
    parameter int ADDR_WIDTH     = 32,
    parameter int G_HISTORY_BITS = 8,
    parameter int DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in0_valid,
    input  logic [ADDR_WIDTH-1:0]     in0_pc,
    input  logic [G_HISTORY_BITS-1:0] in0_ghistory,
    input  logic [2:0]                in0_pred,
    input  logic                      in0_outcome,
    input  logic                      in1_valid,
    input  logic [ADDR_WIDTH-1:0]     in1_pc,
    input  logic [G_HISTORY_BITS-1:0] in1_ghistory,
    input  logic [2:0]                in1_pred,
    input  logic                      in1_outcome,
    output logic                      in_ready,
    output logic                      upd_valid,
    output logic [ADDR_WIDTH-1:0]     upd_pc,
    output logic [G_HISTORY_BITS-1:0] upd_ghistory,
    output logic [2:0]                upd_pred,
    output logic                      upd_outcome,
    output logic                      hist_restore_valid,
    output logic [G_HISTORY_BITS-1:0] hist_restore_value,
    output logic                      init_we,
    output logic [G_HISTORY_BITS-1:0] init_index,
    output logic [31:0]               mispredict_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_WIDTH + G_HISTORY_BITS + 4;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CNT_W-1:0]          READY_MAX = CNT_W'(DEPTH - 2);
    localparam logic [G_HISTORY_BITS-1:0] INIT_LAST = '1;
    localparam logic [G_HISTORY_BITS-1:0] IDX_ONE   = G_HISTORY_BITS'(1);

    logic [0:0]                state_q, state_d;
    logic [G_HISTORY_BITS-1:0] init_index_q, init_index_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [31:0]               mispredict_count_q, mispredict_count_d;
    logic [ENTRY_W-1:0]        mem_q [DEPTH];
    logic [ENTRY_W-1:0]        mem_d [DEPTH];

    logic               accept0, accept1, pop;
    logic [ENTRY_W-1:0] entry0, entry1, head;

    assign entry0 = {in0_pc, in0_ghistory, in0_pred, in0_outcome};
    assign entry1 = {in1_pc, in1_ghistory, in1_pred, in1_outcome};
    assign head   = mem_q[rd_ptr_q];

    // Outputs are forced idle while rst is held so a mid-operation reset never issues a stale head.
    assign in_ready  = !rst && (state_q == ST_RUN) && (count_q <= READY_MAX);
    assign upd_valid = !rst && (state_q == ST_RUN) && (count_q != '0);

    assign upd_outcome  = head[0];
    assign upd_pred     = head[3:1];
    assign upd_ghistory = head[G_HISTORY_BITS+3:4];
    assign upd_pc       = head[ENTRY_W-1 -: ADDR_WIDTH];

    assign hist_restore_valid = upd_valid && (upd_pred[2] != upd_outcome);
    assign hist_restore_value = {upd_ghistory[G_HISTORY_BITS-2:0], upd_outcome};

    assign init_we          = (state_q == ST_INIT);
    assign init_index       = init_index_q;
    assign mispredict_count = mispredict_count_q;

    assign accept0 = in_ready && in0_valid;
    assign accept1 = in_ready && in1_valid;
    assign pop     = upd_valid;

    always_comb begin
        state_d      = state_q;
        init_index_d = init_index_q;
        if (state_q == ST_INIT) begin
            if (init_index_q == INIT_LAST) begin
                state_d      = ST_RUN;
                init_index_d = '0;
            end else begin
                init_index_d = init_index_q + IDX_ONE;
            end
        end
    end

    // in1 lands directly behind in0 when both are taken, or at the tail alone when only in1 is valid.
    always_comb begin
        mem_d = mem_q;
        if (accept0) begin
            mem_d[wr_ptr_q] = entry0;
        end
        if (accept1) begin
            mem_d[wr_ptr_q + PTR_W'(accept0)] = entry1;
        end
        wr_ptr_d           = wr_ptr_q + PTR_W'(accept0) + PTR_W'(accept1);
        rd_ptr_d           = rd_ptr_q + PTR_W'(pop);
        count_d            = count_q + CNT_W'(accept0) + CNT_W'(accept1) - CNT_W'(pop);
        mispredict_count_d = mispredict_count_q + 32'(hist_restore_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= ST_INIT;
            init_index_q       <= '0;
            wr_ptr_q           <= '0;
            rd_ptr_q           <= '0;
            count_q            <= '0;
            mispredict_count_q <= '0;
        end else begin
            state_q            <= state_d;
            init_index_q       <= init_index_d;
            wr_ptr_q           <= wr_ptr_d;
            rd_ptr_q           <= rd_ptr_d;
            count_q            <= count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_branch_update_scheduler.sv
// Directed, table-driven bench for branch_update_scheduler (ADDR_WIDTH=32, G_HISTORY_BITS=8, DEPTH=4).
module tb_branch_update_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        in0_valid, in0_outcome, in1_valid, in1_outcome;
    logic [31:0] in0_pc, in1_pc;
    logic [7:0]  in0_ghistory, in1_ghistory;
    logic [2:0]  in0_pred, in1_pred;
    logic        in_ready, upd_valid, upd_outcome, hist_restore_valid, init_we;
    logic [31:0] upd_pc, mispredict_count;
    logic [7:0]  upd_ghistory, hist_restore_value, init_index;
    logic [2:0]  upd_pred;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    branch_update_scheduler #(.ADDR_WIDTH(32), .G_HISTORY_BITS(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_pc(in0_pc), .in0_ghistory(in0_ghistory),
        .in0_pred(in0_pred), .in0_outcome(in0_outcome),
        .in1_valid(in1_valid), .in1_pc(in1_pc), .in1_ghistory(in1_ghistory),
        .in1_pred(in1_pred), .in1_outcome(in1_outcome),
        .in_ready(in_ready), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_ghistory(upd_ghistory), .upd_pred(upd_pred), .upd_outcome(upd_outcome),
        .hist_restore_valid(hist_restore_valid), .hist_restore_value(hist_restore_value),
        .init_we(init_we), .init_index(init_index), .mispredict_count(mispredict_count)
    );

    typedef struct {
        logic        v0; logic [31:0] pc0; logic [7:0] gh0; logic [2:0] pr0; logic o0;
        logic        v1; logic [31:0] pc1; logic [7:0] gh1; logic [2:0] pr1; logic o1;
        logic        e_ready;
        logic        e_upd;
        logic [31:0] e_pc;
        logic [7:0]  e_gh;
        logic        e_out;
        logic        e_hrv;
        logic [31:0] e_mc;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [31:0] pc0, input logic [7:0] gh0,
                                 input logic [2:0] pr0, input logic o0,
                                 input logic v1, input logic [31:0] pc1, input logic [7:0] gh1,
                                 input logic [2:0] pr1, input logic o1);
        in0_valid = v0; in0_pc = pc0; in0_ghistory = gh0; in0_pred = pr0; in0_outcome = o0;
        in1_valid = v1; in1_pc = pc1; in1_ghistory = gh1; in1_pred = pr1; in1_outcome = o1;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        check({tag, ".in_ready"}, 64'(in_ready), 64'(v.e_ready));
        check({tag, ".upd_valid"}, 64'(upd_valid), 64'(v.e_upd));
        check({tag, ".hist_restore_valid"}, 64'(hist_restore_valid), 64'(v.e_hrv));
        check({tag, ".mispredict_count"}, 64'(mispredict_count), 64'(v.e_mc));
        if (v.e_upd) begin
            check({tag, ".upd_pc"}, 64'(upd_pc), 64'(v.e_pc));
            check({tag, ".upd_ghistory"}, 64'(upd_ghistory), 64'(v.e_gh));
            check({tag, ".upd_outcome"}, 64'(upd_outcome), 64'(v.e_out));
            check({tag, ".hist_restore_value"}, 64'(hist_restore_value),
                  64'({v.e_gh[6:0], v.e_out}));
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //            v0 pc0     gh0    pr0 o0  v1 pc1     gh1    pr1 o1  rdy upd pc      gh     out hrv mc
        vecs[0]  = '{1, 32'h40,  8'h00, 7, 1,  0, 32'h0,   8'h00, 0, 0,  1,  0,  32'h0,   8'h00, 0,  0,  0};
        vecs[1]  = '{0, 32'h0,   8'h00, 0, 0,  0, 32'h0,   8'h00, 0, 0,  1,  1,  32'h40,  8'h00, 1,  0,  0};
        vecs[2]  = '{0, 32'h0,   8'h00, 0, 0,  0, 32'h0,   8'h00, 0, 0,  1,  0,  32'h0,   8'h00, 0,  0,  0};
        vecs[3]  = '{1, 32'h100, 8'h11, 7, 1,  1, 32'h104, 8'h22, 0, 0,  1,  0,  32'h0,   8'h00, 0,  0,  0};
        vecs[4]  = '{1, 32'h108, 8'h33, 7, 1,  1, 32'h10C, 8'h44, 0, 0,  1,  1,  32'h100, 8'h11, 1,  0,  0};
        vecs[5]  = '{1, 32'h110, 8'h55, 7, 1,  1, 32'h114, 8'h66, 0, 0,  0,  1,  32'h104, 8'h22, 0,  0,  0};
        vecs[6]  = '{0, 32'h0,   8'h00, 0, 0,  0, 32'h0,   8'h00, 0, 0,  1,  1,  32'h108, 8'h33, 1,  0,  0};
        vecs[7]  = '{0, 32'h0,   8'h00, 0, 0,  0, 32'h0,   8'h00, 0, 0,  1,  1,  32'h10C, 8'h44, 0,  0,  0};
        vecs[8]  = '{0, 32'h0,   8'h00, 0, 0,  0, 32'h0,   8'h00, 0, 0,  1,  0,  32'h0,   8'h00, 0,  0,  0};
        vecs[9]  = '{1, 32'h200, 8'hA5, 4, 0,  0, 32'h0,   8'h00, 0, 0,  1,  0,  32'h0,   8'h00, 0,  0,  0};
        vecs[10] = '{0, 32'h0,   8'h00, 0, 0,  0, 32'h0,   8'h00, 0, 0,  1,  1,  32'h200, 8'hA5, 0,  1,  0};
        vecs[11] = '{0, 32'h0,   8'h00, 0, 0,  0, 32'h0,   8'h00, 0, 0,  1,  0,  32'h0,   8'h00, 0,  0,  1};
        vecs[12] = '{0, 32'h0,   8'h00, 0, 0,  1, 32'h300, 8'h3C, 0, 1,  1,  0,  32'h0,   8'h00, 0,  0,  1};
        vecs[13] = '{0, 32'h0,   8'h00, 0, 0,  0, 32'h0,   8'h00, 0, 0,  1,  1,  32'h300, 8'h3C, 1,  1,  1};
        vecs[14] = '{0, 32'h0,   8'h00, 0, 0,  0, 32'h0,   8'h00, 0, 0,  1,  0,  32'h0,   8'h00, 0,  0,  2};

        // Reset: outputs idle while rst is held.
        tick();
        tick();
        check("reset.in_ready", 64'(in_ready), 64'(0));
        check("reset.upd_valid", 64'(upd_valid), 64'(0));
        check("reset.hist_restore_valid", 64'(hist_restore_valid), 64'(0));
        check("reset.mispredict_count", 64'(mispredict_count), 64'(0));
        check("reset.init_index", 64'(init_index), 64'(0));
        rst = 1'b0;

        // Init walk over all 256 indices; commits offered here must be ignored.
        applyStimulus(1, 32'hDEAD, 8'h01, 7, 0, 1, 32'hBEEF, 8'h02, 0, 1);
        for (int i = 0; i < 256; i++) begin
            check($sformatf("init%0d.init_we", i), 64'(init_we), 64'(1));
            check($sformatf("init%0d.init_index", i), 64'(init_index), 64'(i));
            if (i == 0 || i == 255) begin
                check($sformatf("init%0d.in_ready", i), 64'(in_ready), 64'(0));
                check($sformatf("init%0d.upd_valid", i), 64'(upd_valid), 64'(0));
            end
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("run.init_we", 64'(init_we), 64'(0));
        check("run.init_index", 64'(init_index), 64'(0));
        check("run.in_ready", 64'(in_ready), 64'(1));
        check("run.upd_valid", 64'(upd_valid), 64'(0));

        for (int k = 0; k < 15; k++) begin
            applyStimulus(vecs[k].v0, vecs[k].pc0, vecs[k].gh0, vecs[k].pr0, vecs[k].o0,
                          vecs[k].v1, vecs[k].pc1, vecs[k].gh1, vecs[k].pr1, vecs[k].o1);
            checkOutput(k, vecs[k]);
            tick();
        end

        // Queue three entries, then reset mid-operation.
        applyStimulus(1, 32'h400, 8'h01, 7, 1, 1, 32'h404, 8'h02, 7, 1);
        tick();
        applyStimulus(1, 32'h408, 8'h03, 7, 1, 1, 32'h40C, 8'h04, 7, 1);
        check("midrst.pre_upd_pc", 64'(upd_pc), 64'(32'h400));
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("midrst.pre_upd_valid", 64'(upd_valid), 64'(1));
        check("midrst.pre_in_ready", 64'(in_ready), 64'(0));
        rst = 1'b1;
        #1;
        check("midrst.rst_upd_valid", 64'(upd_valid), 64'(0));
        check("midrst.rst_in_ready", 64'(in_ready), 64'(0));
        tick();
        rst = 1'b0;
        check("midrst.upd_valid", 64'(upd_valid), 64'(0));
        check("midrst.init_we", 64'(init_we), 64'(1));
        check("midrst.init_index", 64'(init_index), 64'(0));
        check("midrst.mispredict_count", 64'(mispredict_count), 64'(0));
        tick();
        check("midrst.init_index1", 64'(init_index), 64'(1));
        for (int i = 0; i < 255; i++) tick();
        check("midrst.run_in_ready", 64'(in_ready), 64'(1));
        check("midrst.run_upd_valid", 64'(upd_valid), 64'(0));
        check("midrst.run_init_we", 64'(init_we), 64'(0));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/branch_update_scheduler.md
Name: branch_update_scheduler

Overview:
Sits between the ROB commit stage and the tournament branch predictor's feedback port. It accepts up to two committed branches per cycle and buffers them in order in a small FIFO. It then issues exactly one predictor update per cycle and generates the global-history restore on a mispredicted update. After reset it also sequences a walk over every predictor table index so the tables are initialised without initial blocks.

Parameters:
ADDR_WIDTH, 32, PC width
G_HISTORY_BITS, 8, global history width; predictor tables have 2^G_HISTORY_BITS entries
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in0_valid  input  1  older committed branch valid
in0_pc  input  ADDR_WIDTH  PC of in0
in0_ghistory  input  G_HISTORY_BITS  history used when in0 was predicted
in0_pred  input  3  {final, gshare, 2bit} predictions of in0 (1 = TAKEN)
in0_outcome  input  1  resolved direction of in0
in1_valid, in1_pc, in1_ghistory, in1_pred, in1_outcome  input  same widths  younger committed branch
in_ready  output  1  scheduler can accept two branches this cycle
upd_valid  output  1  predictor feedback valid
upd_pc, upd_ghistory, upd_pred, upd_outcome  output  as in0_*  head entry fields
hist_restore_valid  output  1  predictor must load hist_restore_value into ghistory
hist_restore_value  output  G_HISTORY_BITS  {head ghistory[G_HISTORY_BITS-2:0], head outcome}
init_we  output  1  write reset value to table entry init_index
init_index  output  G_HISTORY_BITS  table index being initialised
mispredict_count  output  32  number of issued updates with final pred != outcome

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled at posedge clk.
- States: INIT, RUN.
- Reset values: state=INIT, init_index=0, FIFO empty (rd_ptr=wr_ptr=count=0), mispredict_count=0.
- Outputs in reset cycle: in_ready=0, upd_valid=0, hist_restore_valid=0.
- INIT:
  - init_we=1 every cycle; init_index increments by 1 per cycle.
  - When init_index == 2^G_HISTORY_BITS-1, the next state is RUN and init_index returns to 0.
  - INIT lasts exactly 2^G_HISTORY_BITS cycles.
  - in_ready=0 and upd_valid=0 throughout; commits offered during INIT are ignored.
- RUN: init_we=0. in_ready = (count <= DEPTH-2), combinational from registered count.
- Enqueue (only when in_ready=1):
  - in0 is written before in1.
  - If only in1_valid is set, in1 is written as a single entry.
  - nin = in0_valid + in1_valid (0..2).
  - wr_ptr advances by nin modulo DEPTH.
- Dequeue:
  - upd_valid = (state==RUN) && (count != 0); upd_* are combinational from the head entry.
  - Head pops every cycle upd_valid=1. The predictor has no backpressure.
  - rd_ptr advances by 1 modulo DEPTH.
- Count update: count_next = count + nin_accepted - pop, every cycle. Simultaneous enqueue of 2 and pop of 1 is legal. Pointer wrap-around is by natural overflow.
- Latency: a branch accepted at edge t, into an empty FIFO, appears on upd_* during cycle t+1. Per-cycle throughput is 1 update, so a burst of 2 drains in 2 cycles.
- Ordering: updates are issued strictly in commit order; in0 always precedes in1 of the same cycle.
- Mispredict handling:
  - hist_restore_valid = upd_valid && (upd_pred[2] != upd_outcome), asserted in the same cycle as the update.
  - mispredict_count increments by 1 at that edge and wraps at 2^32.
- Overflow: the FIFO never overflows, because in_ready guarantees room for 2. Valid inputs while in_ready=0 are dropped; the ROB must hold them.
- Reset mid-operation: FIFO contents are discarded, mispredict_count is cleared, and the block restarts INIT from index 0.

Test Plan:
- Reset with G_HISTORY_BITS=3 → init_we=1 for 8 cycles, init_index 0..7; in_ready rises on cycle 9 with upd_valid=0.
- In RUN, single in0 (pc=0x40, pred=3'b111, outcome=1) → next cycle upd_valid=1, upd_pc=0x40, hist_restore_valid=0; FIFO then empty.
- Both inputs valid for 3 consecutive cycles (6 branches, DEPTH=4) → in_ready drops when count>2; all accepted branches issue in order, one per cycle, none lost or duplicated.
- Head with ghistory=8'hA5, pred final=1, outcome=0 → hist_restore_valid=1, hist_restore_value=8'h4A, mispredict_count 0→1.
- in1_valid only (in0_valid=0) → exactly one entry enqueued; count=1; upd_pc equals in1_pc.
- rst asserted with 3 entries queued → next cycle upd_valid=0 and count=0; INIT restarts at index 0.
